instr_fetch: RTL and testbench

- Instruction fetch stage directly upstream of the unified memory; issues byte reads to memory and consumes its registered `memdata`.
- Code region holds one instruction byte per word, in `memdata[7:0]`. Four consecutive bytes form one 32-bit instruction, big-endian (lowest address = `instr[31:24]`).
- Presents each completed instruction plus its PC to decode over a valid/ready handshake.
- Supports PC redirect (branch/jump) and a stall input for when the data-side owns the memory port.

---
 rtl/instr_fetch.sv | 121 ++++++++++++
 tb/tb_instr_fetch.sv | 395 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: reads four byte-wide code words per instruction and assembles them
// big-endian, then hands the instruction and its PC to decode over a valid/ready handshake.
module instr_fetch #(
  parameter int unsigned ADDR_W   = 11,
  parameter int unsigned DATA_W   = 24,
  parameter int unsigned RESET_PC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fetch_en,
  input  logic              mem_stall,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_load_value,
  output logic              mem_read,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [DATA_W-1:0] memdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain, StValid} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [2:0]          i_q, i_d;
  logic [2:0]          k_q, k_d;
  logic                cap_pend_q, cap_pend_d;
  logic [31:0]         instr_q, instr_d;
  logic [ADDR_W-1:0]   instr_pc_q, instr_pc_d;

  // Only the low byte of each code word carries instruction data.
  logic                unused_memdata;
  assign unused_memdata = ^memdata[DATA_W-1:8];

  assign mem_address = pc_q + ADDR_W'(i_q);
  assign instr_valid = (state_q == StValid);
  assign busy        = (state_q == StFetch) || (state_q == StDrain);
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    i_d         = i_q;
    k_d         = k_q;
    instr_d     = instr_q;
    instr_pc_d  = instr_pc_q;
    mem_read    = (state_q == StFetch) && !mem_stall && !pc_load;
    cap_pend_d  = mem_read;

    // Memory data is registered, so the byte for a read lands one cycle later.
    if (cap_pend_q) begin
      unique case (k_q[1:0])
        2'd0: instr_d[31:24] = memdata[7:0];
        2'd1: instr_d[23:16] = memdata[7:0];
        2'd2: instr_d[15:8]  = memdata[7:0];
        2'd3: instr_d[7:0]   = memdata[7:0];
        default: ;
      endcase
      k_d = k_q + 3'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (fetch_en) state_d = StFetch;
      end
      StFetch: begin
        if (mem_read) begin
          i_d = i_q + 3'd1;
          if (i_q == 3'd3) state_d = StDrain;
        end
      end
      StDrain: begin
        instr_pc_d = pc_q;
        state_d    = StValid;
      end
      StValid: begin
        if (instr_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          i_d     = 3'd0;
          k_d     = 3'd0;
          state_d = fetch_en ? StFetch : StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Redirect overrides everything, including a simultaneous handshake.
    if (pc_load) begin
      pc_d       = pc_load_value;
      i_d        = 3'd0;
      k_d        = 3'd0;
      cap_pend_d = 1'b0;
      state_d    = fetch_en ? StFetch : StIdle;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      pc_q       <= ADDR_W'(RESET_PC);
      i_q        <= 3'd0;
      k_q        <= 3'd0;
      cap_pend_q <= 1'b0;
      instr_q    <= 32'd0;
      instr_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      i_q        <= i_d;
      k_q        <= k_d;
      cap_pend_q <= cap_pend_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: directed scenarios plus a randomized run against a
// PC/memory scoreboard.
module tb_instr_fetch;

  localparam int ADDR_W = 11;
  localparam int DATA_W = 24;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              fetch_en;
  logic              mem_stall;
  logic              pc_load;
  logic [ADDR_W-1:0] pc_load_value;
  logic              mem_read;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] memdata;
  logic              instr_valid;
  logic              instr_ready;
  logic [31:0]       instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              busy;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem [2048];

  instr_fetch #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(1024)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fetch_en      (fetch_en),
    .mem_stall     (mem_stall),
    .pc_load       (pc_load),
    .pc_load_value (pc_load_value),
    .mem_read      (mem_read),
    .mem_address   (mem_address),
    .memdata       (memdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Registered memory; garbage when no read so stray captures show up.
  always @(posedge clk) begin
    if (mem_read) memdata <= {16'($urandom), mem[mem_address]};
    else          memdata <= 24'($urandom);
  end

  function automatic logic [31:0] word_at(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] a1, a2, a3;
    a1 = a + 11'd1;
    a2 = a + 11'd2;
    a3 = a + 11'd3;
    return {mem[a], mem[a1], mem[a2], mem[a3]};
  endfunction

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0; fetch_en = 1'b0; mem_stall = 1'b0; pc_load = 1'b0;
    pc_load_value = '0; instr_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  // Returns the number of cycles until instr_valid, or -1 if the bound expires.
  task automatic wait_valid(input int max, output int n);
    n = -1;
    for (int c = 0; c < max && n < 0; c++) begin
      #1;
      if (instr_valid) n = c;
      else step();
    end
  endtask

  task automatic load_program();
    logic [31:0] w [4];
    w = '{32'h01800110, 32'h01800220, 32'h00044300, 32'h010C0030};
    for (int j = 0; j < 4; j++)
      for (int b = 0; b < 4; b++) mem[1024 + 4*j + b] = w[j][31-8*b -: 8];
  endtask

  task automatic test_reset();
    rst_n = 1'b0; fetch_en = 1'b0; mem_stall = 1'b0; pc_load = 1'b0;
    pc_load_value = '0; instr_ready = 1'b0;
    step();
    #1;
    total++;
    if (instr !== 32'd0 || instr_pc !== 11'd0 || instr_valid !== 1'b0 || mem_read !== 1'b0 ||
        mem_address !== 11'd1024 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: instr=%h pc=%0d valid=%b rd=%b addr=%0d busy=%b, required 0/0/0/0/1024/0",
               instr, instr_pc, instr_valid, mem_read, mem_address, busy);
    end
  endtask

  task automatic test_first_fetch();
    int n;
    apply_reset();
    load_program();
    fetch_en = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (mem_read !== 1'b1 || mem_address !== 11'(1024 + c)) begin
        bad++;
        $display("FAIL first_read%0d: rd=%b addr=%0d, required 1/%0d", c, mem_read, mem_address,
                 1024 + c);
      end
      step();
    end
    wait_valid(10, n);
    total++;
    if (n !== 1) begin
      bad++;
      $display("FAIL first_latency: valid at cycle %0d, required cycle 5", n < 0 ? n : n + 4);
    end
    total++;
    if (instr !== 32'h01800110 || instr_pc !== 11'd1024) begin
      bad++;
      $display("FAIL first_instr: instr=%h pc=%0d, required 01800110/1024", instr, instr_pc);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_w [4];
    int cnt;
    exp_w = '{32'h01800110, 32'h01800220, 32'h00044300, 32'h010C0030};
    cnt = 0;
    apply_reset();
    load_program();
    fetch_en = 1'b1;
    instr_ready = 1'b1;
    step();
    for (int c = 0; c < 24; c++) begin
      #1;
      if (instr_valid && cnt < 4) begin
        total++;
        if (instr !== exp_w[cnt] || instr_pc !== 11'(1024 + 4*cnt) || c != 5 + 6*cnt) begin
          bad++;
          $display("FAIL b2b_%0d: instr=%h pc=%0d cycle=%0d, required %h/%0d/%0d", cnt, instr,
                   instr_pc, c, exp_w[cnt], 1024 + 4*cnt, 5 + 6*cnt);
        end
        cnt++;
      end
      step();
    end
    instr_ready = 1'b0;
    total++;
    if (cnt != 4) begin
      bad++;
      $display("FAIL b2b_count: got %0d instructions, required 4", cnt);
    end
  endtask

  task automatic test_stall();
    int first;
    first = -1;
    apply_reset();
    load_program();
    fetch_en = 1'b1;
    step();
    for (int c = 0; c < 12; c++) begin
      mem_stall = (c >= 2 && c <= 4);
      #1;
      if (mem_stall) begin
        total++;
        if (mem_read !== 1'b0) begin
          bad++;
          $display("FAIL stall_read%0d: rd=%b, required 0", c, mem_read);
        end
      end
      if (instr_valid && first < 0) first = c;
      step();
    end
    mem_stall = 1'b0;
    total++;
    if (first != 8 || instr !== 32'h01800110) begin
      bad++;
      $display("FAIL stall_result: valid at %0d instr=%h, required 8/01800110", first, instr);
    end
  endtask

  task automatic test_hold();
    int n;
    apply_reset();
    load_program();
    fetch_en = 1'b1;
    step();
    wait_valid(20, n);
    total++;
    if (n != 5) begin
      bad++;
      $display("FAIL hold_latency: valid at %0d, required 5", n);
    end
    for (int c = 0; c < 10; c++) begin
      #1;
      total++;
      if (instr_valid !== 1'b1 || instr !== 32'h01800110 || instr_pc !== 11'd1024 ||
          mem_read !== 1'b0) begin
        bad++;
        $display("FAIL hold_cycle%0d: valid=%b instr=%h pc=%0d rd=%b, required 1/01800110/1024/0",
                 c, instr_valid, instr, instr_pc, mem_read);
      end
      step();
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    #1;
    total++;
    if (instr_valid !== 1'b0 || mem_read !== 1'b1 || mem_address !== 11'd1028) begin
      bad++;
      $display("FAIL hold_advance: valid=%b rd=%b addr=%0d, required 0/1/1028", instr_valid,
               mem_read, mem_address);
    end
    wait_valid(20, n);
    total++;
    if (n < 0 || instr !== 32'h01800220 || instr_pc !== 11'd1028) begin
      bad++;
      $display("FAIL hold_next: n=%0d instr=%h pc=%0d, required 01800220/1028", n, instr, instr_pc);
    end
  endtask

  task automatic test_redirect();
    int n;
    apply_reset();
    load_program();
    fetch_en = 1'b1;
    step();
    step();
    step();
    pc_load = 1'b1;
    pc_load_value = 11'd1032;
    #1;
    total++;
    if (mem_read !== 1'b0) begin
      bad++;
      $display("FAIL redirect_read: rd=%b during pc_load, required 0", mem_read);
    end
    step();
    pc_load = 1'b0;
    #1;
    total++;
    if (mem_read !== 1'b1 || mem_address !== 11'd1032) begin
      bad++;
      $display("FAIL redirect_addr: rd=%b addr=%0d, required 1/1032", mem_read, mem_address);
    end
    wait_valid(20, n);
    total++;
    if (n != 5 || instr !== 32'h00044300 || instr_pc !== 11'd1032) begin
      bad++;
      $display("FAIL redirect_instr: n=%0d instr=%h pc=%0d, required 5/00044300/1032", n, instr,
               instr_pc);
    end
  endtask

  task automatic test_wrap_and_async_reset();
    int n;
    apply_reset();
    mem[2046] = 8'hAA; mem[2047] = 8'hBB; mem[0] = 8'hCC; mem[1] = 8'hDD;
    fetch_en = 1'b1;
    pc_load = 1'b1;
    pc_load_value = 11'd2046;
    step();
    pc_load = 1'b0;
    for (int c = 0; c < 4; c++) begin
      #1;
      total++;
      if (mem_read !== 1'b1 || mem_address !== 11'((2046 + c) % 2048)) begin
        bad++;
        $display("FAIL wrap_read%0d: rd=%b addr=%0d, required 1/%0d", c, mem_read, mem_address,
                 (2046 + c) % 2048);
      end
      step();
    end
    wait_valid(10, n);
    total++;
    if (n != 1 || instr !== 32'hAABBCCDD || instr_pc !== 11'd2046) begin
      bad++;
      $display("FAIL wrap_instr: n=%0d instr=%h pc=%0d, required 1/aabbccdd/2046", n, instr,
               instr_pc);
    end
    instr_ready = 1'b1;
    step();
    instr_ready = 1'b0;
    step();
    #1;
    total++;
    if (busy !== 1'b1 || mem_address !== 11'd3) begin
      bad++;
      $display("FAIL wrap_refetch: busy=%b addr=%0d, required 1/3", busy, mem_address);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (instr !== 32'd0 || instr_pc !== 11'd0 || instr_valid !== 1'b0 || mem_read !== 1'b0 ||
        mem_address !== 11'd1024 || busy !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: instr=%h pc=%0d valid=%b rd=%b addr=%0d busy=%b, required 0/0/0/0/1024/0",
               instr, instr_pc, instr_valid, mem_read, mem_address, busy);
    end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [ADDR_W-1:0] model_pc;
    logic [ADDR_W-1:0] off;
    logic [31:0]       held;
    logic              holding;
    int                nhs;
    for (int a = 0; a < 2048; a++) mem[a] = 8'($urandom);
    apply_reset();
    model_pc = 11'd1024;
    holding = 1'b0;
    held = '0;
    nhs = 0;
    for (int c = 0; c < 3000; c++) begin
      fetch_en      = ($urandom % 8) != 0;
      mem_stall     = ($urandom % 4) == 0;
      instr_ready   = ($urandom % 3) != 0;
      pc_load       = ($urandom % 40) == 0;
      pc_load_value = 11'($urandom);
      #1;
      if (holding) begin
        total++;
        if (instr_valid !== 1'b1 || instr !== held) begin
          bad++;
          $display("FAIL rnd_hold c%0d: valid=%b instr=%h, required 1/%h", c, instr_valid, instr,
                   held);
        end
      end
      if (mem_read) begin
        off = mem_address - model_pc;
        total++;
        if (mem_stall || pc_load || instr_valid || off > 11'd3) begin
          bad++;
          $display("FAIL rnd_read c%0d: addr=%0d stall=%b load=%b valid=%b, required pc %0d..+3 unblocked",
                   c, mem_address, mem_stall, pc_load, instr_valid, model_pc);
        end
      end
      if (instr_valid && instr_ready) begin
        total++;
        nhs++;
        if (instr !== word_at(model_pc) || instr_pc !== model_pc) begin
          bad++;
          $display("FAIL rnd_instr c%0d: instr=%h pc=%0d, required %h/%0d", c, instr, instr_pc,
                   word_at(model_pc), model_pc);
        end
      end
      holding = instr_valid && !instr_ready && !pc_load;
      held    = instr;
      if (pc_load) model_pc = pc_load_value;
      else if (instr_valid && instr_ready) model_pc = model_pc + 11'd4;
      step();
    end
    pc_load = 1'b0;
    total++;
    if (nhs < 50) begin
      bad++;
      $display("FAIL rnd_progress: %0d handshakes, required at least 50", nhs);
    end
  endtask

  initial begin
    for (int a = 0; a < 2048; a++) mem[a] = 8'h00;
    test_reset();
    test_first_fetch();
    test_back_to_back();
    test_stall();
    test_hold();
    test_redirect();
    test_wrap_and_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
